// File: rtl/croc_pkg.sv
// Shared user-domain OBI subordinate types plus the register map of the
// GPIO interrupt block (user_gpio_irq).
package croc_pkg;

  localparam int unsigned SbrObiAddrWidth = 32;
  localparam int unsigned SbrObiDataWidth = 32;
  localparam int unsigned SbrObiIdWidth   = 4;

  typedef struct packed {
    logic [SbrObiAddrWidth-1:0]   addr;
    logic                         we;
    logic [SbrObiDataWidth/8-1:0] be;
    logic [SbrObiDataWidth-1:0]   wdata;
    logic [SbrObiIdWidth-1:0]     aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [SbrObiDataWidth-1:0] rdata;
    logic [SbrObiIdWidth-1:0]   rid;
    logic                       err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  // Word index taken from addr[4:2]; indices 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    UGI_REG_IN       = 3'd0,
    UGI_REG_RISE_EN  = 3'd1,
    UGI_REG_FALL_EN  = 3'd2,
    UGI_REG_PENDING  = 3'd3,
    UGI_REG_IRQ_EN   = 3'd4,
    UGI_REG_DEBOUNCE = 3'd5
  } user_gpio_irq_reg_e;

  localparam logic [31:0] UserGpioIrqInOffset       = 32'h00;
  localparam logic [31:0] UserGpioIrqRiseEnOffset   = 32'h04;
  localparam logic [31:0] UserGpioIrqFallEnOffset   = 32'h08;
  localparam logic [31:0] UserGpioIrqPendingOffset  = 32'h0C;
  localparam logic [31:0] UserGpioIrqIrqEnOffset    = 32'h10;
  localparam logic [31:0] UserGpioIrqDebounceOffset = 32'h14;

  function automatic logic [31:0] obi_byte_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debouncer: the filtered level follows the raw input only after
// the raw level has differed for threshold+1 consecutive clock edges.
module gpio_debounce
  import croc_pkg::*;
#(
  parameter int unsigned DebounceWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     raw_i,
  input  logic [DebounceWidth-1:0] threshold_i,
  output logic                     filtered_o
);

  logic                     r_filtered;
  logic [DebounceWidth-1:0] r_count;
  logic                     w_mismatch;
  logic                     w_done;

  assign w_mismatch = raw_i ^ r_filtered;
  // ">=" so a counter left above a freshly lowered threshold fires immediately.
  assign w_done     = (r_count >= threshold_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filtered <= 1'b0;
      r_count    <= '0;
    end else if (!w_mismatch) begin
      r_count <= '0;
    end else if (w_done) begin
      r_filtered <= raw_i;
      r_count    <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign filtered_o = r_filtered;

endmodule

// File: rtl/user_gpio_irq.sv
// GPIO edge-interrupt controller on an OBI subordinate port: debounced inputs,
// per-pin rise/fall enables, W1C pending bits and a registered level IRQ.
module user_gpio_irq
  import croc_pkg::*;
#(
  parameter int unsigned GpioCount     = 2,
  parameter int unsigned DebounceWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  sbr_obi_req_t         obi_req_i,
  output sbr_obi_rsp_t         obi_rsp_o,
  input  logic [GpioCount-1:0] gpio_in_sync_i,
  output logic                 irq_o
);

  logic [GpioCount-1:0]     r_rise_en;
  logic [GpioCount-1:0]     r_fall_en;
  logic [GpioCount-1:0]     r_pending;
  logic [GpioCount-1:0]     r_irq_en;
  logic [DebounceWidth-1:0] r_debounce;
  logic [GpioCount-1:0]     r_filtered_q;
  logic                     r_irq;
  logic                     r_rvalid;
  logic [31:0]              r_rdata;
  logic                     r_err;
  logic [SbrObiIdWidth-1:0] r_rid;

  logic [GpioCount-1:0] w_filtered;
  logic [GpioCount-1:0] w_set;
  logic [GpioCount-1:0] w_clr;
  logic [2:0]           w_reg_idx;
  logic                 w_legal;
  logic                 w_wr;
  logic [31:0]          w_wmask;
  logic [31:0]          w_wbits;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  for (genvar g = 0; g < GpioCount; g++) begin : g_pin
    gpio_debounce #(
      .DebounceWidth(DebounceWidth)
    ) u_debounce (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .raw_i      (gpio_in_sync_i[g]),
      .threshold_i(r_debounce),
      .filtered_o (w_filtered[g])
    );
  end

  assign w_reg_idx = obi_req_i.a.addr[4:2];
  assign w_legal   = (w_reg_idx <= UGI_REG_DEBOUNCE);
  assign w_wr      = obi_req_i.req & obi_req_i.a.we & w_legal;
  assign w_wmask   = obi_byte_mask(obi_req_i.a.be);
  assign w_wbits   = obi_req_i.a.wdata & w_wmask;
  assign w_unused  = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0], w_wbits, w_wmask};

  assign w_set = ((w_filtered & ~r_filtered_q) & r_rise_en)
               | ((~w_filtered & r_filtered_q) & r_fall_en);
  assign w_clr = (w_wr && (w_reg_idx == UGI_REG_PENDING)) ? w_wbits[GpioCount-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    if (!obi_req_i.a.we) begin
      case (w_reg_idx)
        UGI_REG_IN:       w_rdata[GpioCount-1:0]     = w_filtered;
        UGI_REG_RISE_EN:  w_rdata[GpioCount-1:0]     = r_rise_en;
        UGI_REG_FALL_EN:  w_rdata[GpioCount-1:0]     = r_fall_en;
        UGI_REG_PENDING:  w_rdata[GpioCount-1:0]     = r_pending;
        UGI_REG_IRQ_EN:   w_rdata[GpioCount-1:0]     = r_irq_en;
        UGI_REG_DEBOUNCE: w_rdata[DebounceWidth-1:0] = r_debounce;
        default:          w_rdata                    = '0;
      endcase
    end
  end

  // Config registers; a hardware set on PENDING overrides a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rise_en    <= '0;
      r_fall_en    <= '0;
      r_pending    <= '0;
      r_irq_en     <= '0;
      r_debounce   <= '0;
      r_filtered_q <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_filtered_q <= w_filtered;
      r_irq        <= |(r_pending & r_irq_en);
      r_pending    <= (r_pending & ~w_clr) | w_set;
      if (w_wr && (w_reg_idx == UGI_REG_RISE_EN))
        r_rise_en <= (r_rise_en & ~w_wmask[GpioCount-1:0]) | w_wbits[GpioCount-1:0];
      if (w_wr && (w_reg_idx == UGI_REG_FALL_EN))
        r_fall_en <= (r_fall_en & ~w_wmask[GpioCount-1:0]) | w_wbits[GpioCount-1:0];
      if (w_wr && (w_reg_idx == UGI_REG_IRQ_EN))
        r_irq_en <= (r_irq_en & ~w_wmask[GpioCount-1:0]) | w_wbits[GpioCount-1:0];
      if (w_wr && (w_reg_idx == UGI_REG_DEBOUNCE))
        r_debounce <= (r_debounce & ~w_wmask[DebounceWidth-1:0]) | w_wbits[DebounceWidth-1:0];
    end
  end

  // Handshake: gnt mirrors req (every request is accepted the cycle it is
  // presented); each accepted request produces exactly one rvalid pulse on the
  // following cycle, and the response channel has no backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rid    <= '0;
    end else begin
      r_rvalid <= obi_req_i.req;
      if (obi_req_i.req) begin
        r_rdata <= w_rdata;
        r_err   <= ~w_legal;
        r_rid   <= obi_req_i.a.aid;
      end
    end
  end

  assign obi_rsp_o.gnt     = obi_req_i.req;
  assign obi_rsp_o.rvalid  = r_rvalid;
  assign obi_rsp_o.r.rdata = r_rdata;
  assign obi_rsp_o.r.rid   = r_rid;
  assign obi_rsp_o.r.err   = r_err;
  assign irq_o             = r_irq;

endmodule

// File: tb/tb_user_gpio_irq.sv
// Bench for user_gpio_irq: directed scenarios followed by random register
// traffic and pin activity, all checked against a behavioural model.
module tb_user_gpio_irq;
  import croc_pkg::*;

  localparam int unsigned GPIO_N = 2;
  localparam int unsigned DEB_W  = 16;
  localparam int unsigned W      = 32 + 1 + SbrObiIdWidth;
  localparam logic [31:0] LIM    = 32'((64'd1 << GPIO_N) - 1);
  localparam logic [31:0] DLIM   = 32'((64'd1 << DEB_W) - 1);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  sbr_obi_req_t      obi_req;
  sbr_obi_rsp_t      obi_rsp;
  logic [GPIO_N-1:0] gpio;
  logic              irq;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Behavioural model state
  logic [31:0] m_in, m_prev, m_rise_en, m_fall_en, m_pend, m_irq_en, m_deb;
  logic        m_irq, m_rvalid;
  int          m_streak[GPIO_N];

  user_gpio_irq #(
    .GpioCount    (GPIO_N),
    .DebounceWidth(DEB_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .obi_req_i     (obi_req),
    .obi_rsp_o     (obi_rsp),
    .gpio_in_sync_i(gpio),
    .irq_o         (irq)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  initial begin
    #10000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in = '0; m_prev = '0; m_rise_en = '0; m_fall_en = '0;
    m_pend = '0; m_irq_en = '0; m_deb = '0; m_irq = 1'b0; m_rvalid = 1'b0;
    for (int i = 0; i < GPIO_N; i++) m_streak[i] = 0;
    exp_q.delete();
  endtask

  // One rising clock edge worth of behaviour, from the register-map rules.
  task automatic model_edge();
    logic [31:0] rd, bm, wv, set, clr, old_in;
    logic [2:0]  idx;
    logic        legal;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    idx   = obi_req.a.addr[4:2];
    legal = (idx <= 3'd5);
    case (idx)
      3'd0:    rd = m_in;
      3'd1:    rd = m_rise_en;
      3'd2:    rd = m_fall_en;
      3'd3:    rd = m_pend;
      3'd4:    rd = m_irq_en;
      3'd5:    rd = m_deb;
      default: rd = 32'd0;
    endcase
    bm = 32'd0;
    for (int b = 0; b < 4; b++) if (obi_req.a.be[b]) bm[8*b +: 8] = 8'hFF;
    wv  = obi_req.a.wdata & bm;
    set = ((m_in & ~m_prev) & m_rise_en) | ((~m_in & m_prev) & m_fall_en);
    clr = 32'd0;
    m_irq    = |(m_pend & m_irq_en);
    m_rvalid = obi_req.req;
    if (obi_req.req)
      exp_q.push_back({(obi_req.a.we ? 32'd0 : rd), ~legal, obi_req.a.aid});
    // A pin's level is accepted once it has differed for DEBOUNCE+1 edges in a row.
    old_in = m_in;
    for (int i = 0; i < GPIO_N; i++) begin
      if (gpio[i] != old_in[i]) begin
        m_streak[i]++;
        if (m_streak[i] > int'(m_deb)) begin
          m_in[i]     = gpio[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_prev = old_in;
    if (obi_req.req && obi_req.a.we) begin
      case (idx)
        3'd1: m_rise_en = ((m_rise_en & ~bm) | wv) & LIM;
        3'd2: m_fall_en = ((m_fall_en & ~bm) | wv) & LIM;
        3'd3: clr       = wv & LIM;
        3'd4: m_irq_en  = ((m_irq_en & ~bm) | wv) & LIM;
        3'd5: m_deb     = ((m_deb & ~bm) | wv) & DLIM;
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    check("irq", {63'd0, irq}, {63'd0, m_irq});
    check("rvalid", {63'd0, obi_rsp.rvalid}, {63'd0, m_rvalid});
    if (m_rvalid) begin
      e = exp_q.pop_front();
      check("rdata", {32'd0, obi_rsp.r.rdata}, {32'd0, e[W-1 -: 32]});
      check("err", {63'd0, obi_rsp.r.err}, {63'd0, e[SbrObiIdWidth]});
      check("rid", {60'd0, obi_rsp.r.rid}, {60'd0, e[SbrObiIdWidth-1:0]});
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare_outputs();
  endtask

  // Driver: presents one request for one cycle; returns the rdata seen after it.
  task automatic obi_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata);
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = addr;
    obi_req.a.wdata = wdata;
    obi_req.a.be    = be;
    obi_req.a.aid   = 4'($urandom_range(0, 15));
    #1;
    check("gnt", {63'd0, obi_rsp.gnt}, 64'd1);
    tick();
    rdata = obi_rsp.r.rdata;
    obi_req.req  = 1'b0;
    obi_req.a.we = 1'b0;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    obi_access(1'b1, addr, data, 4'hF, dummy);
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    obi_access(1'b0, addr, 32'd0, 4'hF, data);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    obi_req = '0;
    gpio    = '0;
    model_reset();

    // Reset state
    rst_ni = 1'b0;
    repeat (3) tick();
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_rvalid", {63'd0, obi_rsp.rvalid}, 64'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reg_read(32'(i * 4), d);
      check($sformatf("rst_reg%0d", i), {32'd0, d}, 64'd0);
    end

    // Zero debounce: IN after edge k, PENDING after k+1, irq after k+2
    reg_write(UserGpioIrqDebounceOffset, 32'd0);
    reg_write(UserGpioIrqRiseEnOffset, 32'd1);
    reg_write(UserGpioIrqIrqEnOffset, 32'd1);
    gpio[0] = 1'b1;
    tick();
    reg_read(UserGpioIrqInOffset, d);
    check("in_after_k", {32'd0, d}, 64'd1);
    check("irq_k1", {63'd0, irq}, 64'd0);
    reg_read(UserGpioIrqPendingOffset, d);
    check("pend_after_k1", {32'd0, d}, 64'd1);
    check("irq_k2", {63'd0, irq}, 64'd1);

    // W1C colliding with a new rising edge: set wins
    gpio[0] = 1'b0;
    repeat (2) tick();
    reg_write(UserGpioIrqPendingOffset, 32'd1);
    reg_read(UserGpioIrqPendingOffset, d);
    check("w1c_clear", {32'd0, d}, 64'd0);
    gpio[0] = 1'b1;
    tick();
    reg_write(UserGpioIrqPendingOffset, 32'd1);
    reg_read(UserGpioIrqPendingOffset, d);
    check("w1c_vs_set", {32'd0, d}, 64'd1);

    // DEBOUNCE=3: 3-cycle glitch rejected, 4-cycle pulse accepted
    reg_write(UserGpioIrqDebounceOffset, 32'd3);
    reg_write(UserGpioIrqRiseEnOffset, 32'd3);
    reg_write(UserGpioIrqPendingOffset, 32'd3);
    gpio[1] = 1'b1;
    repeat (3) tick();
    gpio[1] = 1'b0;
    repeat (2) tick();
    reg_read(UserGpioIrqInOffset, d);
    check("glitch_in", {32'd0, d}, 64'd1);
    reg_read(UserGpioIrqPendingOffset, d);
    check("glitch_pend", {32'd0, d}, 64'd0);
    gpio[1] = 1'b1;
    repeat (4) tick();
    gpio[1] = 1'b0;
    reg_read(UserGpioIrqInOffset, d);
    check("pulse_in", {32'd0, d}, 64'd3);
    repeat (6) tick();

    // Illegal offset and read-only IN
    reg_read(32'h1C, d);
    check("illegal_rdata", {32'd0, d}, 64'd0);
    check("illegal_err", {63'd0, obi_rsp.r.err}, 64'd1);
    reg_write(UserGpioIrqInOffset, 32'd0);
    reg_read(UserGpioIrqInOffset, d);
    check("in_ro", {32'd0, d}, 64'd1);

    // Byte-lane write clipped to GPIO width
    reg_write(UserGpioIrqRiseEnOffset, 32'd0);
    obi_access(1'b1, UserGpioIrqRiseEnOffset, 32'hFFFF_FFFF, 4'b0001, d);
    reg_read(UserGpioIrqRiseEnOffset, d);
    check("be_rise", {32'd0, d}, 64'd3);

    // Reset right after a granted read: response dropped
    gpio = '0;
    obi_req.req     = 1'b1;
    obi_req.a.we    = 1'b0;
    obi_req.a.addr  = UserGpioIrqRiseEnOffset;
    obi_req.a.aid   = 4'd5;
    @(posedge clk_i);
    model_edge();
    #1;
    rst_ni = 1'b0;
    obi_req.req = 1'b0;
    model_reset();
    @(negedge clk_i);
    check("rst_drop_rvalid", {63'd0, obi_rsp.rvalid}, 64'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      reg_read(32'(i * 4), d);
      check($sformatf("post_rst_reg%0d", i), {32'd0, d}, 64'd0);
    end

    // Pins already high across reset release produce a rising edge
    rst_ni = 1'b0;
    gpio   = 2'b11;
    repeat (2) tick();
    rst_ni = 1'b1;
    reg_write(UserGpioIrqRiseEnOffset, 32'd3);
    reg_read(UserGpioIrqPendingOffset, d);
    reg_read(UserGpioIrqPendingOffset, d);
    check("post_rst_rise", {32'd0, d}, 64'd3);

    // Random traffic against the model
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = $urandom_range(0, GPIO_N - 1);
        gpio[p] = ~gpio[p];
      end
      a = 32'($urandom_range(0, 7)) << 2;
      case ($urandom_range(0, 3))
        0: tick();
        1: reg_read(a, d);
        2: begin
          if (a == UserGpioIrqDebounceOffset)
            obi_access(1'b1, a, 32'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), d);
          else
            obi_access(1'b1, a, $urandom, 4'($urandom_range(0, 15)), d);
        end
        default: reg_read(UserGpioIrqPendingOffset, d);
      endcase
    end
    repeat (4) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
